// File: rtl/enemy_sprite_unit.sv
// Per-pixel enemy sprite stage: 3-clock bounding-box/ROM pipeline plus per-enemy walk-animation FSMs.
// Optional hit-flash whitening is built when HIT_FLASH_EN is defined.
module enemy_sprite_unit #(
  parameter int unsigned ENEMY_NUM = 4,
  parameter int unsigned SPR_W     = 32,
  parameter int unsigned SPR_H     = 32,
  parameter int unsigned FRAMES    = 4,
  parameter int unsigned ANIM_DIV  = 8
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         pix_en,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  input  logic                         frame_start,
  input  logic [ENEMY_NUM-1:0][9:0]    enemy_x,
  input  logic [ENEMY_NUM-1:0][9:0]    enemy_y,
  input  logic [ENEMY_NUM-1:0]         enemy_alive,
  input  logic [ENEMY_NUM-1:0]         enemy_moving,
  input  logic [ENEMY_NUM-1:0][1:0]    enemy_dir,
`ifdef HIT_FLASH_EN
  input  logic [ENEMY_NUM-1:0]         enemy_hit,
`endif
  output logic [ENEMY_NUM-1:0][13:0]   rom_addr,
  input  logic [ENEMY_NUM-1:0][4:0]    rom_data,
  output logic [ENEMY_NUM-1:0]         is_enemy,
  output logic [ENEMY_NUM-1:0][4:0]    enemy_index,
  output logic                         out_valid
);

  localparam int unsigned FW = $clog2(FRAMES);
  localparam int unsigned XW = $clog2(SPR_W);
  localparam int unsigned YW = $clog2(SPR_H);
  localparam int unsigned DW = $clog2(ANIM_DIV);

  typedef enum logic {IDLE, WALK} anim_state_t;

  anim_state_t         state   [ENEMY_NUM];
  anim_state_t         state_n [ENEMY_NUM];
  logic [FW-1:0]       frame   [ENEMY_NUM];
  logic [FW-1:0]       frame_n [ENEMY_NUM];
  logic [DW-1:0]       div     [ENEMY_NUM];
  logic [DW-1:0]       div_n   [ENEMY_NUM];
  logic [FW-1:0]       frame_t [ENEMY_NUM];
  logic [DW-1:0]       div_t   [ENEMY_NUM];

  logic [9:0]           lx [ENEMY_NUM];
  logic [9:0]           ly [ENEMY_NUM];
  logic [ENEMY_NUM-1:0] hit0, hit1, hit2;
  logic                 v1, v2;
  logic [ENEMY_NUM-1:0][4:0] idx_n;

  always_comb begin
    for (int unsigned i = 0; i < ENEMY_NUM; i++) begin
      lx[i]   = DrawX - enemy_x[i];
      ly[i]   = DrawY - enemy_y[i];
      hit0[i] = enemy_alive[i] && (lx[i] < 10'(SPR_W)) && (ly[i] < 10'(SPR_H));
    end
  end

  // IDLE always holds frame 0 / divider 0, so the pulse that enters WALK
  // counts as the first divider tick using the same step arithmetic.
  always_comb begin
    for (int unsigned i = 0; i < ENEMY_NUM; i++) begin
      if (div[i] == DW'(ANIM_DIV - 1)) begin
        div_t[i]   = '0;
        frame_t[i] = frame[i] + 1'b1;
      end else begin
        div_t[i]   = div[i] + 1'b1;
        frame_t[i] = frame[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < ENEMY_NUM; i++) begin
      state_n[i] = state[i];
      frame_n[i] = frame[i];
      div_n[i]   = div[i];
      if (frame_start) begin
        unique case (state[i])
          IDLE: if (enemy_moving[i] && enemy_alive[i]) begin
            state_n[i] = WALK;
            frame_n[i] = frame_t[i];
            div_n[i]   = div_t[i];
          end
          WALK: if (!(enemy_moving[i] && enemy_alive[i])) begin
            state_n[i] = IDLE;
            frame_n[i] = '0;
            div_n[i]   = '0;
          end else begin
            frame_n[i] = frame_t[i];
            div_n[i]   = div_t[i];
          end
          default: state_n[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int unsigned i = 0; i < ENEMY_NUM; i++) begin
      if (Reset) begin
        state[i] <= IDLE;
        frame[i] <= '0;
        div[i]   <= '0;
      end else begin
        state[i] <= state_n[i];
        frame[i] <= frame_n[i];
        div[i]   <= div_n[i];
      end
    end
  end

`ifdef HIT_FLASH_EN
  logic [ENEMY_NUM-1:0][3:0] flash_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      flash_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < ENEMY_NUM; i++) begin
        if (enemy_hit[i])
          flash_cnt[i] <= 4'd15;
        else if (frame_start && flash_cnt[i] != 4'd0)
          flash_cnt[i] <= flash_cnt[i] - 4'd1;
      end
    end
  end
`endif

  always_comb begin
    for (int unsigned i = 0; i < ENEMY_NUM; i++) begin
      idx_n[i] = (hit2[i] && v2) ? rom_data[i] : 5'd0;
`ifdef HIT_FLASH_EN
      if (flash_cnt[i] != 4'd0 && flash_cnt[i][1] && idx_n[i] != 5'd0)
        idx_n[i] = 5'd2;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr    <= '0;
      hit1        <= '0;
      hit2        <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      is_enemy    <= '0;
      enemy_index <= '0;
      out_valid   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < ENEMY_NUM; i++)
        rom_addr[i] <= {enemy_dir[i], frame[i], ly[i][YW-1:0], lx[i][XW-1:0]};
      hit1        <= hit0;
      v1          <= pix_en;
      hit2        <= hit1;
      v2          <= v1;
      is_enemy    <= hit2 & {ENEMY_NUM{v2}};
      enemy_index <= idx_n;
      out_valid   <= v2;
    end
  end

endmodule
